add_share_ctrl: RTL and testbench

//   Round-robin controller that shares one 32-bit CLA add/sub unit (combinational,

---
 rtl/add_share_ctrl.sv | 126 ++++++++++++
 tb/tb_add_share_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_share_ctrl.sv
// Round-robin arbiter that shares one external add/sub unit among NUM_REQ requesters.
// One issue stage drives the adder and one response stage returns the result to its owner.
module add_share_ctrl #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 32,
   localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [NUM_REQ*WIDTH-1:0] req_a,
   input  logic [NUM_REQ*WIDTH-1:0] req_b,
   input  logic [NUM_REQ-1:0]       req_ci,
   input  logic [NUM_REQ-1:0]       req_sub,
   input  logic [NUM_REQ-1:0]       req_sign,
   input  logic [NUM_REQ-1:0]       req_chain,
   output logic [WIDTH-1:0]         add_a,
   output logic [WIDTH-1:0]         add_b,
   output logic                     add_ci,
   output logic                     add_sub,
   output logic                     add_sign,
   input  logic [WIDTH-1:0]         add_s,
   input  logic                     add_co,
   input  logic                     add_ovf,
   output logic [NUM_REQ-1:0]       rsp_valid,
   output logic [ID_W-1:0]          rsp_id,
   output logic [WIDTH-1:0]         rsp_s,
   output logic                     rsp_co,
   output logic                     rsp_ovf
);

   typedef enum logic {StArb, StLocked} state_t;

   state_t          state;
   logic [ID_W-1:0] rr_ptr;
   logic [ID_W-1:0] owner;
   logic            iss_valid;
   logic [ID_W-1:0] iss_id;

   logic            grant_any;
   logic [ID_W-1:0] grant_id;
   logic [ID_W-1:0] sel_id;
   logic            accept;
   logic [ID_W-1:0] rr_next;
   logic [WIDTH-1:0] sel_a;
   logic [WIDTH-1:0] sel_b;

   // First valid requester at or above rr_ptr, wrapping around.
   always_comb begin
      grant_any = 1'b0;
      grant_id  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!grant_any && req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
            grant_any = 1'b1;
            grant_id  = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (state == StLocked) begin
         req_ready[owner] = req_valid[owner];
      end else if (grant_any) begin
         req_ready[grant_id] = 1'b1;
      end
   end

   always_comb begin
      sel_id  = (state == StLocked) ? owner : grant_id;
      accept  = |(req_valid & req_ready);
      sel_a   = req_a[int'(sel_id)*WIDTH +: WIDTH];
      sel_b   = req_b[int'(sel_id)*WIDTH +: WIDTH];
      rr_next = (int'(sel_id) == NUM_REQ - 1) ? '0 : sel_id + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= StArb;
         rr_ptr    <= '0;
         owner     <= '0;
         iss_valid <= 1'b0;
         iss_id    <= '0;
         add_a     <= '0;
         add_b     <= '0;
         add_ci    <= 1'b0;
         add_sub   <= 1'b0;
         add_sign  <= 1'b0;
         rsp_valid <= '0;
         rsp_id    <= '0;
         rsp_s     <= '0;
         rsp_co    <= 1'b0;
         rsp_ovf   <= 1'b0;
      end else begin
         iss_valid <= accept;
         // Operand regs hold across stalls so add_co still reflects the previous chained beat.
         if (accept) begin
            iss_id   <= sel_id;
            add_a    <= sel_a;
            add_b    <= sel_b;
            add_sub  <= req_sub[sel_id];
            add_sign <= req_sign[sel_id];
            // Adder applies ci^sub internally, so this recovers the previous raw carry.
            add_ci   <= (state == StLocked) ? (add_co ^ req_sub[sel_id]) : req_ci[sel_id];
            if (req_chain[sel_id]) begin
               state <= StLocked;
               owner <= sel_id;
            end else begin
               state  <= StArb;
               rr_ptr <= rr_next;
            end
         end

         rsp_valid <= '0;
         if (iss_valid) begin
            rsp_valid[iss_id] <= 1'b1;
            rsp_id            <= iss_id;
            rsp_s             <= add_s;
            rsp_co            <= add_co;
            rsp_ovf           <= add_ovf;
         end
      end
   end

endmodule

// File: tb/tb_add_share_ctrl.sv
// Bench for add_share_ctrl: a behavioural adder, a queued beat driver and a scoreboard monitor
// checking hand-computed responses in expected grant order.
module tb_add_share_ctrl;

   localparam int N = 4;
   localparam int W = 32;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   req_valid = '0;
   logic [N-1:0]   req_ready;
   logic [N*W-1:0] req_a = '0;
   logic [N*W-1:0] req_b = '0;
   logic [N-1:0]   req_ci = '0;
   logic [N-1:0]   req_sub = '0;
   logic [N-1:0]   req_sign = '0;
   logic [N-1:0]   req_chain = '0;
   logic [W-1:0]   add_a, add_b, add_s;
   logic           add_ci, add_sub, add_sign, add_co, add_ovf;
   logic [N-1:0]   rsp_valid;
   logic [1:0]     rsp_id;
   logic [W-1:0]   rsp_s;
   logic           rsp_co, rsp_ovf;

   add_share_ctrl #(.NUM_REQ(N), .WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_ci(req_ci), .req_sub(req_sub),
      .req_sign(req_sign), .req_chain(req_chain),
      .add_a(add_a), .add_b(add_b), .add_ci(add_ci), .add_sub(add_sub), .add_sign(add_sign),
      .add_s(add_s), .add_co(add_co), .add_ovf(add_ovf),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_s(rsp_s), .rsp_co(rsp_co), .rsp_ovf(rsp_ovf)
   );

   always #5 clk = ~clk;

   // Shared adder: carry-in is ci^sub; unsigned overflow is carry (add) or borrow (sub).
   logic [W:0]   sum_full;
   logic [W-1:0] b_eff;
   always_comb begin
      b_eff    = add_sub ? ~add_b : add_b;
      sum_full = {1'b0, add_a} + {1'b0, b_eff} + {{W{1'b0}}, add_ci ^ add_sub};
      add_s    = sum_full[W-1:0];
      add_co   = sum_full[W];
      add_ovf  = add_sign ? ((add_a[W-1] == b_eff[W-1]) && (add_s[W-1] != add_a[W-1]))
                          : (add_co ^ add_sub);
   end

   typedef struct {
      int         rid;
      logic [W-1:0] a, b;
      logic       ci, sub, sign, chain;
      int         gap;
   } beat_t;

   typedef struct {
      int         rid;
      logic [W-1:0] s;
      logic       co, ovf;
   } exp_t;

   beat_t bq[$];
   exp_t  sb[$];
   int    n_vec = 0;
   int    n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic beat(input int rid, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ci, input logic sub, input logic sign, input logic chain,
                       input int gap);
      beat_t t;
      t.rid = rid; t.a = a; t.b = b; t.ci = ci; t.sub = sub; t.sign = sign;
      t.chain = chain; t.gap = gap;
      bq.push_back(t);
   endtask

   task automatic expect_rsp(input int rid, input logic [W-1:0] s, input logic co,
                             input logic ovf);
      exp_t e;
      e.rid = rid; e.s = s; e.co = co; e.ovf = ovf;
      sb.push_back(e);
   endtask

   function automatic int find_beat(input int r);
      for (int k = 0; k < bq.size(); k++) if (bq[k].rid == r) return k;
      return -1;
   endfunction

   function automatic int pending(input int r);
      int c = 0;
      for (int k = 0; k < bq.size(); k++) if (bq[k].rid == r) c++;
      return c;
   endfunction

   // Driver: presents each requester's head beat, pops it once it has been accepted.
   always begin
      logic [N-1:0] fire;
      @(negedge clk);
      req_valid = '0; req_a = '0; req_b = '0; req_ci = '0;
      req_sub = '0; req_sign = '0; req_chain = '0;
      if (rst_n) begin
         for (int i = 0; i < N; i++) begin
            int idx;
            idx = find_beat(i);
            if (idx >= 0) begin
               if (bq[idx].gap > 0) begin
                  bq[idx].gap = bq[idx].gap - 1;
               end else begin
                  req_valid[i]       = 1'b1;
                  req_a[i*W +: W]    = bq[idx].a;
                  req_b[i*W +: W]    = bq[idx].b;
                  req_ci[i]          = bq[idx].ci;
                  req_sub[i]         = bq[idx].sub;
                  req_sign[i]        = bq[idx].sign;
                  req_chain[i]       = bq[idx].chain;
               end
            end
         end
      end
      #3;
      fire = req_valid & req_ready;
      @(posedge clk);
      for (int i = 0; i < N; i++) begin
         if (fire[i]) bq.delete(find_beat(i));
      end
   end

   // Monitor: every response must match the next scoreboard entry.
   always @(negedge clk) begin
      if (rst_n && rsp_valid != '0) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_rsp: got rsp_valid=%b, expected none", rsp_valid);
         end else begin
            exp_t e;
            logic [N-1:0] one;
            e   = sb.pop_front();
            one = 4'b0001;
            chk("rsp_valid", 64'(rsp_valid), 64'(one << e.rid));
            chk("rsp_id", 64'(rsp_id), 64'(e.rid));
            chk("rsp_s", 64'(rsp_s), 64'(e.s));
            chk("rsp_co", 64'(rsp_co), 64'(e.co));
            chk("rsp_ovf", 64'(rsp_ovf), 64'(e.ovf));
         end
      end
   end

   task automatic drain(input string name, input int lim);
      int c = 0;
      while ((bq.size() != 0 || sb.size() != 0) && c < lim) begin
         @(posedge clk); #1;
         c++;
      end
      n_vec++;
      if (bq.size() != 0 || sb.size() != 0) begin
         n_err++;
         $display("FAIL drain_%s: got %0d beats / %0d rsp pending, expected 0 / 0",
                  name, bq.size(), sb.size());
         bq.delete();
         sb.delete();
      end
   endtask

   task automatic wait_pending(input string name, input int r, input int left, input int lim);
      int c = 0;
      while (pending(r) > left && c < lim) begin
         @(posedge clk); #1;
         c++;
      end
      n_vec++;
      if (pending(r) > left) begin
         n_err++;
         $display("FAIL accept_%s: got %0d beats pending, expected %0d", name, pending(r), left);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk); #2;
      chk("idle_ready", 64'(req_ready), 64'h0);

      // 1: reset during the adder cycle discards the beat and clears everything.
      beat(1, 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 1'b0, 1'b0, 0);
      wait_pending("rst_beat", 1, 0, 20);
      #1 rst_n = 1'b0;
      bq.delete();
      repeat (2) begin
         @(negedge clk); #2;
         chk("rst_add", {add_a, add_b[W-1:3], add_ci, add_sub, add_sign}, 64'h0);
         chk("rst_rsp", {rsp_s, rsp_co, rsp_ovf, rsp_id, rsp_valid}, 64'h0);
      end
      rst_n = 1'b1;

      // 3: all four valid, two beats each; grant order 0,1,2,3,0,1,2,3 from rr_ptr=0.
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < N; i++) begin
            beat(i, 32'h10 * i + 1, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0, 0);
            expect_rsp(i, 32'h101 + 32'h10 * i, 1'b0, 1'b0);
         end
      drain("rr", 100);

      // 2: single add with two-cycle latency.
      beat(1, 32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      expect_rsp(1, 32'h8, 1'b0, 1'b0);
      wait_pending("single", 1, 0, 20);
      @(negedge clk); #2;
      chk("lat_t1", 64'(rsp_valid), 64'h0);
      @(negedge clk); #2;
      chk("lat_t2", 64'(rsp_valid), 64'b0010);
      drain("single", 50);

      // 4: 64-bit add on req2 (rr_ptr=2); req0 must wait until the chain ends.
      beat(2, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0, 1'b1, 0);
      beat(2, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
      beat(0, 32'h7, 32'h8, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      expect_rsp(2, 32'h0, 1'b1, 1'b1);
      expect_rsp(2, 32'h1, 1'b0, 1'b0);
      expect_rsp(0, 32'hF, 1'b0, 1'b0);
      drain("add64", 50);

      // 5: 0x1_0000_0000 - 1 on req1.
      beat(1, 32'h0, 32'h1, 1'b0, 1'b1, 1'b0, 1'b1, 0);
      beat(1, 32'h1, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
      expect_rsp(1, 32'hFFFF_FFFF, 1'b0, 1'b1);
      expect_rsp(1, 32'h0, 1'b1, 1'b0);
      drain("sub64", 50);

      // 6: req3 locks, stalls 3 cycles, then a signed-overflow last beat; req_ci ignored.
      beat(3, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
      beat(3, 32'h7FFF_FFFF, 32'h1, 1'b1, 1'b0, 1'b1, 1'b0, 3);
      expect_rsp(3, 32'h0, 1'b0, 1'b0);
      expect_rsp(3, 32'h8000_0000, 1'b0, 1'b1);
      wait_pending("lock3", 3, 1, 20);
      for (int i = 0; i < 3; i++) begin
         beat(i, 32'(i + 1), 32'(i + 1), 1'b0, 1'b0, 1'b0, 1'b0, 0);
         expect_rsp(i, 32'(2 * (i + 1)), 1'b0, 1'b0);
      end
      repeat (3) begin
         @(negedge clk); #2;
         chk("stall_ready", 64'(req_ready), 64'h0);
      end
      drain("ovf", 50);

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
